// File: rtl/leb128_stream_encoder.sv
// Byte-serial LEB128 encoder: one DATA_W-bit word in, its ULEB128/SLEB128 bytes out
// one per cycle on a valid/ready stream, final byte flagged with out_last.
module leb128_stream_encoder #(
  parameter  int DATA_W    = 32,
  parameter  int SIGNED    = 0,
  localparam int MAX_BYTES = (DATA_W + 6) / 7,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [LEN_W-1:0]  word_len
);

  // The shift register spans a whole number of 7-bit groups so the sign/zero
  // extension covers every byte that can be emitted, including DATA_W < 7.
  localparam int REM_W = MAX_BYTES * 7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]           state_reg, state_next;
  logic [REM_W-1:0]     rem_reg, rem_next;
  logic [LEN_W-1:0]     idx_reg, idx_next;
  logic [LEN_W-1:0]     word_len_reg, word_len_next;

  logic [REM_W-1:0]     ext_data;
  logic [REM_W-1:0]     rem_shift;
  logic [MAX_BYTES-1:0] fits;
  logic [LEN_W-1:0]     load_len;
  logic                 last_raw;
  logic                 emit;
  logic                 fire;
  logic                 last_int;
  logic                 load;

  generate
    if (REM_W > DATA_W) begin : g_ext
      if (SIGNED != 0) begin : g_sext
        assign ext_data = {{(REM_W-DATA_W){in_data[DATA_W-1]}}, in_data};
      end else begin : g_zext
        assign ext_data = {{(REM_W-DATA_W){1'b0}}, in_data};
      end
    end else begin : g_noext
      assign ext_data = in_data;
    end

    if (SIGNED != 0) begin : g_signed
      assign rem_shift = $signed(rem_reg) >>> 7;
      // Final byte once everything from bit 6 upward is pure sign.
      assign last_raw  = (&rem_reg[REM_W-1:6]) | ~(|rem_reg[REM_W-1:6]);
    end else begin : g_unsigned
      assign rem_shift = rem_reg >> 7;
      if (REM_W > 7) begin : g_wide
        assign last_raw = ~(|rem_reg[REM_W-1:7]);
      end else begin : g_narrow
        assign last_raw = 1'b1;
      end
    end

    // fits[gi]: the incoming word encodes in gi+1 bytes.
    for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_fit
      if (gi == MAX_BYTES - 1) begin : g_top
        assign fits[gi] = 1'b1;
      end else if (SIGNED != 0) begin : g_sfit
        assign fits[gi] = (&ext_data[REM_W-1:7*gi+6]) | ~(|ext_data[REM_W-1:7*gi+6]);
      end else begin : g_ufit
        assign fits[gi] = ~(|ext_data[REM_W-1:7*gi+7]);
      end
    end
  endgenerate

  always_comb begin
    load_len = LEN_W'(MAX_BYTES);
    for (int i = MAX_BYTES - 1; i >= 0; i--) begin
      if (fits[i]) load_len = LEN_W'(i + 1);
    end
  end

  assign emit     = (state_reg == ST_EMIT);
  assign last_int = emit && (last_raw || (idx_reg == LEN_W'(MAX_BYTES - 1)));
  assign fire     = emit && out_ready;
  assign in_ready = !emit || (fire && last_int);
  assign load     = in_valid && in_ready;

  always_comb begin
    state_next    = state_reg;
    rem_next      = rem_reg;
    idx_next      = idx_reg;
    word_len_next = word_len_reg;
    if (load) begin
      // Covers both IDLE and the zero-bubble reload on a word's final byte.
      state_next    = ST_EMIT;
      rem_next      = ext_data;
      idx_next      = '0;
      word_len_next = load_len;
    end else if (fire && last_int) begin
      state_next = ST_IDLE;
    end else if (fire) begin
      rem_next = rem_shift;
      idx_next = idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rem_reg      <= '0;
      idx_reg      <= '0;
      word_len_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rem_reg      <= rem_next;
      idx_reg      <= idx_next;
      word_len_reg <= word_len_next;
    end
  end

  assign out_valid = emit;
  assign out_last  = last_int;
  assign out_byte  = emit ? {~last_int, rem_reg[6:0]} : 8'h00;
  assign word_len  = word_len_reg;

endmodule

// File: tb/tb_leb128_stream_encoder.sv
// Scoreboard bench for leb128_stream_encoder: an unsigned and a signed 32-bit
// instance share clk/rst; expected bytes are queued at stimulus time.
module tb_leb128_stream_encoder;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic [2:0] len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [31:0] in_data  [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [7:0]  out_byte [2];
  logic        out_last [2];
  logic [2:0]  word_len [2];

  logic        rdy_force[2];
  logic        bp_en  = 1'b0;
  logic        rnd_bit = 1'b1;

  exp_t exp_u[$];
  exp_t exp_s[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic       st_prev[2];
  logic [7:0] st_byte[2];
  logic       st_last[2];
  logic [2:0] st_len [2];

  always #5 clk = ~clk;

  assign out_ready[0] = rdy_force[0] & (bp_en ? rnd_bit : 1'b1);
  assign out_ready[1] = rdy_force[1];

  leb128_stream_encoder #(.DATA_W(32), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_byte(out_byte[0]),
    .out_last(out_last[0]), .word_len(word_len[0])
  );

  leb128_stream_encoder #(.DATA_W(32), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_byte(out_byte[1]),
    .out_last(out_last[1]), .word_len(word_len[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: compares every handshaked byte against the scoreboard and
  // checks that a stalled byte holds steady until accepted.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      exp_t e;
      int   qn;
      qn = (s == 0) ? exp_u.size() : exp_s.size();
      if (st_prev[s]) begin
        chk($sformatf("hold_valid[%0d]", s), {31'd0, out_valid[s]}, 32'd1);
        chk($sformatf("hold_byte[%0d]", s), {24'd0, out_byte[s]}, {24'd0, st_byte[s]});
        chk($sformatf("hold_last[%0d]", s), {31'd0, out_last[s]}, {31'd0, st_last[s]});
        chk($sformatf("hold_len[%0d]", s), {29'd0, word_len[s]}, {29'd0, st_len[s]});
      end
      st_prev[s] = out_valid[s] && !out_ready[s] && !rst;
      st_byte[s] = out_byte[s];
      st_last[s] = out_last[s];
      st_len[s]  = word_len[s];
      if (!rst && out_valid[s] && qn > 0) begin
        e = (s == 0) ? exp_u[0] : exp_s[0];
        chk($sformatf("in_ready[%0d]", s), {31'd0, in_ready[s]}, {31'd0, out_ready[s] && e.last});
        if (out_ready[s]) begin
          if (s == 0) void'(exp_u.pop_front()); else void'(exp_s.pop_front());
          chk($sformatf("byte[%0d]", s), {24'd0, out_byte[s]}, {24'd0, e.b});
          chk($sformatf("last[%0d]", s), {31'd0, out_last[s]}, {31'd0, e.last});
          chk($sformatf("word_len[%0d]", s), {29'd0, word_len[s]}, {29'd0, e.len});
          $display("dut%0d byte 0x%02h last=%0d len=%0d", s, out_byte[s], out_last[s], word_len[s]);
        end
      end else if (!rst && out_valid[s] && out_ready[s]) begin
        chk($sformatf("unexpected_byte[%0d]", s), {24'd0, out_byte[s]}, 32'hFFFF_FFFF);
      end
    end
  end

  task automatic push_exp(input int s, input logic [39:0] bytes, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.b    = bytes[8*k +: 8];
      e.last = (k == n - 1);
      e.len  = 3'(n);
      if (s == 0) exp_u.push_back(e); else exp_s.push_back(e);
    end
  endtask

  // Offer one word; returns once it has been accepted (first byte in bytes[7:0]).
  task automatic put_word(input int s, input logic [31:0] d, input logic [39:0] bytes, input int n);
    int t;
    push_exp(s, bytes, n);
    in_valid[s] = 1'b1;
    in_data[s]  = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready[s] && t < 80);
    if (!in_ready[s]) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
    in_data[s]  = 32'hDEAD_BEEF;
  endtask

  task automatic drain(input int s);
    int t;
    t = 0;
    while (((s == 0) ? exp_u.size() : exp_s.size()) != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk($sformatf("drained[%0d]", s), (s == 0) ? exp_u.size() : exp_s.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      in_data[s]   = '0;
      rdy_force[s] = 1'b1;
      st_prev[s]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_out_valid", {31'd0, out_valid[s]}, 32'd0);
      chk("rst_out_last",  {31'd0, out_last[s]},  32'd0);
      chk("rst_out_byte",  {24'd0, out_byte[s]},  32'd0);
      chk("rst_word_len",  {29'd0, word_len[s]},  32'd0);
      chk("rst_in_ready",  {31'd0, in_ready[s]},  32'd1);
    end
    @(posedge clk);
    #1;

    // Unsigned vectors
    put_word(0, 32'd0,         40'h00, 1);
    put_word(0, 32'd624485,    40'h26_8E_E5, 3);
    put_word(0, 32'hFFFF_FFFF, 40'h0F_FF_FF_FF_FF, 5);
    put_word(0, 32'd127,       40'h7F, 1);
    put_word(0, 32'd128,       40'h01_80, 2);
    drain(0);

    // Signed vectors
    put_word(1, 32'd63,          40'h3F, 1);
    put_word(1, 32'd64,          40'h00_C0, 2);
    put_word(1, 32'hFFFF_FFC0,   40'h40, 1);
    put_word(1, 32'hFFFF_FFBF,   40'h7F_BF, 2);
    put_word(1, 32'hFFFE_1DC0,   40'h78_BB_C0, 3);
    put_word(1, 32'h8000_0000,   40'h78_80_80_80_80, 5);
    drain(1);

    // Random backpressure on 624485, twice
    bp_en = 1'b1;
    put_word(0, 32'd624485, 40'h26_8E_E5, 3);
    put_word(0, 32'd624485, 40'h26_8E_E5, 3);
    drain(0);
    bp_en = 1'b0;

    // Back-to-back 128 then 1 with in_valid held: 80 01 01, no bubble
    push_exp(0, 40'h01_80, 2);
    push_exp(0, 40'h01, 1);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'd128;
    @(negedge clk);
    chk("b2b_accept0", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk);
    #1 in_data[0] = 32'd1;
    @(negedge clk);
    chk("b2b_valid1", {31'd0, out_valid[0]}, 32'd1);
    chk("b2b_ready1", {31'd0, in_ready[0]}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("b2b_valid2", {31'd0, out_valid[0]}, 32'd1);
    chk("b2b_ready2", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(negedge clk);
    chk("b2b_valid3", {31'd0, out_valid[0]}, 32'd1);
    chk("b2b_byte3",  {24'd0, out_byte[0]},  32'h01);
    drain(0);

    // Reset mid-word: only the first FF of 0xFFFFFFFF goes out
    put_word(0, 32'hFFFF_FFFF, 40'hFF, 1);
    exp_u[0].last = 1'b0;
    exp_u[0].len  = 3'd5;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_force[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_force[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("mid_rst_word_len",  {29'd0, word_len[0]},  32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready[0]},  32'd1);
    chk("mid_rst_q_empty",   exp_u.size(), 32'd0);
    @(posedge clk);
    #1;
    put_word(0, 32'd5, 40'h05, 1);
    drain(0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
